// File: rtl/sm3_pkg.sv
// Shared SM3 message-input types: packed word layout toward the core and
// the MSB-first byte-valid mask helper.
package sm3_pkg;

  localparam int SM3_INPT_DW       = 32;
  localparam int SM3_INPT_BYTE_NUM = 4;

  typedef struct packed {
    logic [SM3_INPT_DW-1:0]       d;
    logic [SM3_INPT_BYTE_NUM-1:0] vld_byte;
    logic                         lst;
  } sm3_word_t;

  // Lane index of the last byte written -> thermometer of valid lanes.
  function automatic logic [SM3_INPT_BYTE_NUM-1:0] sm3_byte_mask(input logic [1:0] idx);
    logic [SM3_INPT_BYTE_NUM-1:0] m;
    case (idx)
      2'd0:    m = 4'b1000;
      2'd1:    m = 4'b1100;
      2'd2:    m = 4'b1110;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sm3_sync_fifo.sv
// Generic single-clock FIFO with registered full/empty flags and a
// combinational head read from the storage array.
module sm3_sync_fifo #(
  parameter int DATA_W = 37,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_d,
  input  logic              pop,
  output logic [DATA_W-1:0] head_d,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(STAGES);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(STAGES);

  logic [DATA_W-1:0] mem [STAGES];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic [AW:0]       cnt_nxt;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_d  = mem[rd_ptr];

  always_comb begin
    cnt_nxt = cnt;
    case ({do_push, do_pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == DEPTH_C);
      empty <= (cnt_nxt == '0);
    end
  end

  // Storage is never read while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_d;
  end

endmodule

// File: rtl/sm3_msg_byte_pack.sv
// Packs a byte-serial message big-endian into 32-bit words for the SM3 core,
// buffering them in a small FIFO and reporting each message's byte length.
module sm3_msg_byte_pack
  import sm3_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 61
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_byte_d,
  input  logic             s_byte_vld,
  input  logic             s_byte_lst,
  output logic             s_byte_rdy,
  output logic [31:0]      msg_inpt_d,
  output logic [3:0]       msg_inpt_vld_byte,
  output logic             msg_inpt_vld,
  output logic             msg_inpt_lst,
  input  logic             msg_inpt_rdy,
  output logic [LEN_W-1:0] msg_len_bytes,
  output logic             msg_len_vld
);

  logic [31:0]      acc_p0;
  logic [1:0]       idx_p0;
  logic [LEN_W-1:0] cnt_p0;
  logic             byte_acc;
  logic             word_push;
  logic             word_pop;
  logic             fifo_full;
  logic             fifo_empty;
  sm3_word_t        push_word;
  sm3_word_t        head_word;

  // Held low through reset so nothing is taken before the FIFO flags settle.
  assign s_byte_rdy = ~rst & ~fifo_full;
  assign byte_acc   = s_byte_vld & s_byte_rdy;
  assign word_push  = byte_acc & ((idx_p0 == 2'd3) | s_byte_lst);

  always_comb begin
    push_word          = '0;
    push_word.d        = acc_p0 | ({s_byte_d, 24'h000000} >> {idx_p0, 3'b000});
    push_word.vld_byte = sm3_byte_mask(idx_p0);
    push_word.lst      = s_byte_lst;
  end

  // Stage p0: byte accumulator, lane index and running length
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p0        <= '0;
      idx_p0        <= '0;
      cnt_p0        <= '0;
      msg_len_bytes <= '0;
      msg_len_vld   <= 1'b0;
    end else begin
      msg_len_vld <= 1'b0;
      if (byte_acc) begin
        if (word_push) begin
          acc_p0 <= '0;
          idx_p0 <= '0;
        end else begin
          acc_p0 <= push_word.d;
          idx_p0 <= idx_p0 + 1'b1;
        end
        if (s_byte_lst) begin
          msg_len_bytes <= cnt_p0 + 1'b1;
          msg_len_vld   <= 1'b1;
          cnt_p0        <= '0;
        end else begin
          cnt_p0 <= cnt_p0 + 1'b1;
        end
      end
    end
  end

  assign word_pop = msg_inpt_vld & msg_inpt_rdy;

  sm3_sync_fifo #(
    .DATA_W ($bits(sm3_word_t)),
    .STAGES (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (word_push),
    .push_d (push_word),
    .pop    (word_pop),
    .head_d (head_word),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Stage p1: FIFO head toward the core, zeroed while nothing is valid
  assign msg_inpt_vld      = ~fifo_empty;
  assign msg_inpt_d        = msg_inpt_vld ? head_word.d        : '0;
  assign msg_inpt_vld_byte = msg_inpt_vld ? head_word.vld_byte : '0;
  assign msg_inpt_lst      = msg_inpt_vld ? head_word.lst      : 1'b0;

endmodule

// File: tb/tb_sm3_msg_byte_pack.sv
// Randomized and directed bench for sm3_msg_byte_pack against a
// byte-queue reference model of the packing and length rules.
module tb_sm3_msg_byte_pack;

  localparam int FIFO_DEPTH = 4;
  localparam int LEN_W      = 61;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       s_byte_d = '0;
  logic             s_byte_vld = 1'b0;
  logic             s_byte_lst = 1'b0;
  logic             s_byte_rdy;
  logic [31:0]      msg_inpt_d;
  logic [3:0]       msg_inpt_vld_byte;
  logic             msg_inpt_vld;
  logic             msg_inpt_lst;
  logic             msg_inpt_rdy = 1'b1;
  logic [LEN_W-1:0] msg_len_bytes;
  logic             msg_len_vld;

  sm3_msg_byte_pack #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .s_byte_d          (s_byte_d),
    .s_byte_vld        (s_byte_vld),
    .s_byte_lst        (s_byte_lst),
    .s_byte_rdy        (s_byte_rdy),
    .msg_inpt_d        (msg_inpt_d),
    .msg_inpt_vld_byte (msg_inpt_vld_byte),
    .msg_inpt_vld      (msg_inpt_vld),
    .msg_inpt_lst      (msg_inpt_lst),
    .msg_inpt_rdy      (msg_inpt_rdy),
    .msg_len_bytes     (msg_len_bytes),
    .msg_len_vld       (msg_len_vld)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bytes of the word being assembled, expected words
  // ({d, mask, lst}) in FIFO order, and the message length bookkeeping.
  logic [7:0]  bq[$];
  logic [36:0] wq[$];
  longint      m_cnt   = 0;
  longint      exp_len = 0;
  bit          len_due = 0;
  bit          rdy_rand = 0;

  function automatic logic [36:0] form_word(input bit lst);
    logic [31:0] d;
    logic [3:0]  m;
    d = '0;
    for (int i = 0; i < bq.size(); i++) d[31-8*i -: 8] = bq[i];
    m = ~(4'hF >> bq.size());
    return {d, m, lst};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rdy_in_rst", s_byte_rdy, 0);
        bq.delete(); wq.delete();
        m_cnt = 0; exp_len = 0; len_due = 0;
      end else begin
        chk("s_byte_rdy", s_byte_rdy, wq.size() < FIFO_DEPTH);
        chk("inpt_vld", msg_inpt_vld, wq.size() != 0);
        if (wq.size() != 0) chk("head", {msg_inpt_d, msg_inpt_vld_byte, msg_inpt_lst}, wq[0]);
        else                chk("idle_zero", {msg_inpt_d, msg_inpt_vld_byte, msg_inpt_lst}, 0);
        chk("len_vld", msg_len_vld, len_due);
        chk("len_bytes", msg_len_bytes, exp_len);
        len_due = 0;
        if (msg_inpt_vld && msg_inpt_rdy && wq.size() != 0) void'(wq.pop_front());
        if (s_byte_vld && s_byte_rdy) begin
          bq.push_back(s_byte_d);
          m_cnt++;
          if (s_byte_lst || bq.size() == 4) begin
            wq.push_back(form_word(s_byte_lst));
            bq.delete();
          end
          if (s_byte_lst) begin
            exp_len = m_cnt; len_due = 1; m_cnt = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) msg_inpt_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic l);
    bit got = 0;
    s_byte_d = b; s_byte_lst = l; s_byte_vld = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_byte_rdy) begin got = 1; break; end
    end
    @(posedge clk); #1;
    s_byte_vld = 1'b0; s_byte_lst = 1'b0; s_byte_d = 8'($urandom);
    if (!got) chk("byte_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    bit done = 0;
    rdy_rand = 0; msg_inpt_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!msg_inpt_vld) begin done = 1; break; end
    end
    @(posedge clk); #1;
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // "abc"
    send_byte(8'h61, 0); send_byte(8'h62, 0); send_byte(8'h63, 1);
    wait_drain();
    chk("t1_len", msg_len_bytes, 3);

    for (int i = 0; i < 8; i++) send_byte(8'(i), i == 7);
    wait_drain();
    chk("t2_len", msg_len_bytes, 8);

    send_byte(8'hAB, 1);
    wait_drain();
    chk("t3_len", msg_len_bytes, 1);

    // Core stalled: FIFO fills after 16 bytes, then released.
    msg_inpt_rdy = 1'b0;
    fork
      for (int i = 0; i < 20; i++) send_byte(8'(i), i == 19);
      begin
        repeat (25) @(negedge clk);
        chk("t4_full_stall", s_byte_rdy, 0);
        chk("t4_head_held", msg_inpt_d, 32'h00010203);
        @(posedge clk); #1 msg_inpt_rdy = 1'b1;
      end
    join
    wait_drain();
    chk("t4_len", msg_len_bytes, 20);

    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), i == 4);
    send_byte(8'h20, 0); send_byte(8'h21, 1);
    wait_drain();
    chk("t5_len", msg_len_bytes, 2);

    // Reset mid-message, then "abc".
    send_byte(8'h55, 0); send_byte(8'h66, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("t6_vld_after_rst", msg_inpt_vld, 0);
    chk("t6_len_after_rst", msg_len_bytes, 0);
    send_byte(8'h61, 0); send_byte(8'h62, 0); send_byte(8'h63, 1);
    wait_drain();
    chk("t6_len", msg_len_bytes, 3);

    // Random messages with random gaps and core backpressure.
    rdy_rand = 1;
    for (int m = 0; m < 40; m++) begin
      int len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        send_byte(8'($urandom), i == len - 1);
      end
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
